// File: rtl/vga_pkg.sv
// Shared VGA constants, colour types and the sprite palette.
// Imported by the sprite renderer and its axis movers.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int CW = 2;

  typedef logic [3*CW-1:0] rgb_t;

  localparam rgb_t PAL_WHITE = 6'b11_11_11;
  localparam rgb_t PAL_RED   = 6'b11_00_00;
  localparam rgb_t PAL_GREEN = 6'b00_11_00;
  localparam rgb_t PAL_BLUE  = 6'b00_00_11;

  localparam logic [CW-1:0] BG_SHADE = 2'b01;

  function automatic rgb_t palette(input logic [1:0] idx);
    rgb_t c;
    unique case (idx)
      2'd0: c = PAL_WHITE;
      2'd1: c = PAL_RED;
      2'd2: c = PAL_GREEN;
      2'd3: c = PAL_BLUE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sprite_bounce_renderer_if.sv
// Timing-in / pixel-out bundle between hvsync_generator side
// and the sprite renderer.
interface sprite_bounce_renderer_if
  import vga_pkg::*;
();

  logic [9:0]    hpos;
  logic [9:0]    vpos;
  logic          display_on;
  logic          hsync_in;
  logic          vsync_in;
  logic [2:0]    speed;
  logic          pause;
  logic [CW-1:0] R;
  logic [CW-1:0] G;
  logic [CW-1:0] B;
  logic          hsync_out;
  logic          vsync_out;
  logic          hit;
  logic          corner;

  modport master (
    output hpos, vpos, display_on,
    output hsync_in, vsync_in,
    output speed, pause,
    input  R, G, B,
    input  hsync_out, vsync_out,
    input  hit, corner
  );

  modport slave (
    input  hpos, vpos, display_on,
    input  hsync_in, vsync_in,
    input  speed, pause,
    output R, G, B,
    output hsync_out, vsync_out,
    output hit, corner
  );

endinterface

// File: rtl/sprite_bounce_renderer_axis.sv
// One axis of sprite motion: steps once per frame update and
// reflects off 0 and LIMIT, pulsing bounce for one cycle.
module sprite_axis_mover
  import vga_pkg::*;
#(
  parameter int LIMIT = H_ACTIVE_DEF - 32,
  parameter int INIT  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       update,
  input  logic [2:0] speed,
  input  logic       pause,
  output logic [9:0] pos,
  output logic       dir,
  output logic       bounce
);

  localparam logic [10:0] MAX = 11'(LIMIT);

  logic [10:0] w_pos;
  logic [10:0] w_spd;
  logic [10:0] w_sum;
  logic        w_step;

  assign w_pos  = {1'b0, pos};
  assign w_spd  = {8'b0, speed};
  assign w_sum  = w_pos + w_spd;
  assign w_step = update && !pause && (speed != 3'd0);

  // dir: 0 = increasing, 1 = decreasing
  always_ff @(posedge clk) begin
    if (reset) begin
      pos    <= 10'(INIT);
      dir    <= 1'b0;
      bounce <= 1'b0;
    end else begin
      bounce <= 1'b0;
      if (w_step) begin
        if (!dir) begin
          if (w_sum >= MAX) begin
            pos    <= MAX[9:0];
            dir    <= 1'b1;
            bounce <= 1'b1;
          end else begin
            pos <= w_sum[9:0];
          end
        end else begin
          if (w_pos <= w_spd) begin
            pos    <= '0;
            dir    <= 1'b0;
            bounce <= 1'b1;
          end else begin
            pos <= pos - {7'b0, speed};
          end
        end
      end
    end
  end

endmodule

// File: rtl/sprite_bounce_renderer.sv
// Bouncing solid sprite over a dim checkerboard; one-cycle
// registered RGB with syncs delayed to stay aligned.
module sprite_bounce_renderer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32,
  parameter int X_INIT   = 0,
  parameter int Y_INIT   = 0
) (
  input logic               clk,
  input logic               reset,
  sprite_bounce_renderer_if.slave bus
);

  logic        w_update;
  logic [9:0]  w_x;
  logic [9:0]  w_y;
  logic        w_bx;
  logic        w_by;
  logic        w_dirx_unused;
  logic        w_diry_unused;
  logic [10:0] w_h;
  logic [10:0] w_v;
  logic [10:0] w_x11;
  logic [10:0] w_y11;
  logic        w_inside;
  rgb_t        w_rgb;
  rgb_t        r_rgb;
  logic        r_hs;
  logic        r_vs;
  logic [1:0]  r_idx;

  // first blanking line, left edge: once per frame
  assign w_update = (bus.hpos == 10'd0)
                 && (bus.vpos == 10'(V_ACTIVE));

  sprite_axis_mover #(
    .LIMIT(H_ACTIVE - SPR_W),
    .INIT (X_INIT)
  ) u_x (
    .clk   (clk),
    .reset (reset),
    .update(w_update),
    .speed (bus.speed),
    .pause (bus.pause),
    .pos   (w_x),
    .dir   (w_dirx_unused),
    .bounce(w_bx)
  );

  sprite_axis_mover #(
    .LIMIT(V_ACTIVE - SPR_H),
    .INIT (Y_INIT)
  ) u_y (
    .clk   (clk),
    .reset (reset),
    .update(w_update),
    .speed (bus.speed),
    .pause (bus.pause),
    .pos   (w_y),
    .dir   (w_diry_unused),
    .bounce(w_by)
  );

  assign w_h   = {1'b0, bus.hpos};
  assign w_v   = {1'b0, bus.vpos};
  assign w_x11 = {1'b0, w_x};
  assign w_y11 = {1'b0, w_y};

  assign w_inside = (w_h >= w_x11)
                 && (w_h < w_x11 + 11'(SPR_W))
                 && (w_v >= w_y11)
                 && (w_v < w_y11 + 11'(SPR_H));

  always_comb begin
    w_rgb = '0;
    if (!bus.display_on) begin
      w_rgb = '0;
    end else if (w_inside) begin
      w_rgb = palette(r_idx);
    end else if (bus.hpos[5] ^ bus.vpos[5]) begin
      w_rgb = {3{BG_SHADE}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb <= '0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_idx <= '0;
    end else begin
      r_rgb <= w_rgb;
      r_hs  <= bus.hsync_in;
      r_vs  <= bus.vsync_in;
      if (w_bx || w_by) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  assign bus.R         = r_rgb[5:4];
  assign bus.G         = r_rgb[3:2];
  assign bus.B         = r_rgb[1:0];
  assign bus.hsync_out = r_hs;
  assign bus.vsync_out = r_vs;
  assign bus.hit       = w_bx | w_by;
  assign bus.corner    = w_bx & w_by;

endmodule

// File: tb/tb_sprite_bounce_renderer.sv
// Scoreboard bench for sprite_bounce_renderer: two instances,
// default origin and a near-corner start.
module tb_sprite_bounce_renderer;

  logic       clk = 1'b0;
  logic       rst0 = 1'b1;
  logic       rst1 = 1'b1;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic       de = 1'b0;
  logic       hs = 1'b0;
  logic       vs = 1'b0;
  logic [2:0] speed = '0;
  logic       pause = 1'b0;

  logic g_r0 = 1'b1;
  logic g_r1 = 1'b1;
  bit   sel = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] W  = 6'b111111;
  localparam logic [5:0] RD = 6'b110000;
  localparam logic [5:0] GR = 6'b001100;
  localparam logic [5:0] BL = 6'b000011;
  localparam logic [5:0] BG = 6'b010101;
  localparam logic [5:0] K  = 6'b000000;

  typedef struct {
    int         cyc;
    logic [9:0] exp;
    bit         sel;
    string      nm;
  } item_t;

  item_t sb[$];

  sprite_bounce_renderer_if if0();
  sprite_bounce_renderer_if if1();

  assign if0.hpos = hpos;
  assign if0.vpos = vpos;
  assign if0.display_on = de;
  assign if0.hsync_in = hs;
  assign if0.vsync_in = vs;
  assign if0.speed = speed;
  assign if0.pause = pause;
  assign if1.hpos = hpos;
  assign if1.vpos = vpos;
  assign if1.display_on = de;
  assign if1.hsync_in = hs;
  assign if1.vsync_in = vs;
  assign if1.speed = speed;
  assign if1.pause = pause;

  sprite_bounce_renderer dut0 (
    .clk  (clk),
    .reset(rst0),
    .bus  (if0)
  );

  sprite_bounce_renderer #(
    .X_INIT(606),
    .Y_INIT(446)
  ) dut1 (
    .clk  (clk),
    .reset(rst1),
    .bus  (if1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  wire [9:0] out0 = {if0.R, if0.G, if0.B, if0.hsync_out,
                     if0.vsync_out, if0.hit, if0.corner};
  wire [9:0] out1 = {if1.R, if1.G, if1.B, if1.hsync_out,
                     if1.vsync_out, if1.hit, if1.corner};

  initial begin
    item_t e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = e.sel ? out1 : out0;
        checks++;
        if (e.cyc != cyc || act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %b want %b (cyc %0d due %0d)",
                   e.nm, act, e.exp, cyc, e.cyc);
        end
      end
    end
  end

  task automatic px(input logic [9:0] h, input logic [9:0] v,
                    input logic d, input logic s_h,
                    input logic s_v, input logic [5:0] rgb,
                    input logic ht, input logic cr,
                    input string nm);
    item_t it;
    logic  ra;
    @(negedge clk);
    rst0 = g_r0;
    rst1 = g_r1;
    hpos = h;
    vpos = v;
    de = d;
    hs = s_h;
    vs = s_v;
    ra = sel ? g_r1 : g_r0;
    it.cyc = cyc + 1;
    it.exp = ra ? 10'd0 : {rgb, s_h, s_v, ht, cr};
    it.sel = sel;
    it.nm = nm;
    sb.push_back(it);
  endtask

  task automatic pr(input logic [9:0] h, input logic [9:0] v,
                    input logic [5:0] rgb, input string nm);
    px(h, v, 1'b1, 1'b0, 1'b0, rgb, 1'b0, 1'b0, nm);
  endtask

  task automatic upd(input logic [2:0] s, input logic p,
                     input logic ht, input logic cr,
                     input string nm);
    speed = s;
    pause = p;
    px(10'd0, 10'd480, 1'b0, 1'b0, 1'b0, K, ht, cr, nm);
    px(10'd0, 10'd481, 1'b0, 1'b0, 1'b1, K, 1'b0, 1'b0,
       {nm, "_after"});
  endtask

  task automatic mv(input int n, input logic [2:0] s);
    for (int i = 0; i < n; i++) upd(s, 1'b0, 1'b0, 1'b0, "move");
  endtask

  initial begin
    // instance 0, origin start
    sel = 1'b0;
    g_r0 = 1'b1;
    px(0, 0, 1, 1, 1, K, 0, 0, "rst_a");
    px(0, 0, 1, 1, 0, K, 0, 0, "rst_b");
    g_r0 = 1'b0;
    px(0, 0, 1, 1, 0, W, 0, 0, "origin_hs");
    px(5, 5, 1, 0, 1, W, 0, 0, "inside_vs");
    pr(40, 5, BG, "bg_right");
    pr(31, 31, W, "last_px");
    pr(32, 31, BG, "right_edge");
    pr(31, 32, BG, "bottom_edge");

    mv(3, 3'd4);
    pr(12, 12, W, "at12");
    pr(11, 12, K, "left_of12");
    pr(43, 12, W, "right12");
    pr(44, 12, BG, "past12");
    pr(20, 44, BG, "below12");

    mv(62, 3'd7);
    pr(446, 446, W, "at446");
    pr(445, 446, K, "left446");
    upd(3'd2, 1'b0, 1'b1, 1'b0, "y_bottom_hit");
    pr(448, 448, RD, "red448");
    pr(448, 447, BG, "above448");

    mv(22, 3'd7);
    pr(602, 294, RD, "red602");
    upd(3'd6, 1'b0, 1'b1, 1'b0, "x_right_hit");
    pr(608, 288, GR, "green608");
    pr(639, 319, GR, "green_br");
    pr(607, 288, BG, "left608");

    mv(41, 3'd7);
    pr(321, 1, GR, "green321");
    upd(3'd1, 1'b0, 1'b1, 1'b0, "y_top_hit");
    pr(320, 0, BL, "blue320");
    pr(352, 0, BG, "right320");

    mv(45, 3'd7);
    pr(5, 315, BL, "blue5");
    upd(3'd3, 1'b0, 1'b0, 1'b0, "x_to2");
    upd(3'd4, 1'b0, 1'b1, 1'b0, "x_left_hit");
    pr(0, 322, W, "wrap_white");
    upd(3'd4, 1'b0, 1'b0, 1'b0, "x_to4");
    pr(4, 326, W, "at4");
    pr(3, 326, K, "left4");
    pr(36, 326, BG, "right4");
    pr(35, 357, W, "corner4");

    for (int i = 0; i < 3; i++)
      upd(3'd4, 1'b1, 1'b0, 1'b0, "paused");
    upd(3'd0, 1'b0, 1'b0, 1'b0, "speed0");
    pause = 1'b1;
    pr(4, 326, W, "frozen");
    pr(36, 326, BG, "frozen_r");
    pr(3, 326, K, "frozen_l");
    pause = 1'b0;
    px(4, 326, 0, 0, 0, K, 0, 0, "blank_inside");

    g_r0 = 1'b1;
    px(4, 326, 1, 1, 0, K, 0, 0, "mid_reset");
    g_r0 = 1'b0;
    pr(0, 0, W, "post_rst");
    pr(32, 0, BG, "post_rst_r");
    upd(3'd4, 1'b0, 1'b0, 1'b0, "post_rst_upd");
    pr(4, 4, W, "post_at4");
    pr(36, 4, BG, "post_r4");
    pr(35, 35, W, "post_br");

    // instance 1, starting two pixels from both limits
    sel = 1'b1;
    g_r0 = 1'b1;
    g_r1 = 1'b1;
    px(606, 446, 1, 1, 1, K, 0, 0, "c_rst_a");
    px(606, 446, 1, 0, 0, K, 0, 0, "c_rst_b");
    g_r1 = 1'b0;
    pr(606, 446, W, "c_init");
    pr(605, 446, BG, "c_left");
    upd(3'd4, 1'b0, 1'b1, 1'b1, "corner_hit");
    pr(608, 448, RD, "c_red");
    pr(639, 479, RD, "c_red_br");
    pr(607, 448, K, "c_left608");
    upd(3'd4, 1'b0, 1'b0, 1'b0, "c_back");
    pr(604, 444, RD, "c_604");
    pr(603, 444, BG, "c_603");

    for (int i = 0; i < 20 && sb.size() > 0; i++)
      @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
